// File: rtl/vproc_vreg_wr_arbiter.sv
// Fair write-port arbiter between execution pipelines and the vector register file.
// Each write port round-robins over its mapped pipes, can lock to one pipe for a burst, and registers the winning write.
module vproc_vreg_wr_arbiter #(
    parameter int unsigned                                VREG_W         = 128,
    parameter int unsigned                                VPORT_WR_CNT   = 1,
    parameter int unsigned                                PIPE_CNT       = 2,
    parameter logic [VPORT_WR_CNT-1:0][PIPE_CNT-1:0]      VPORT_WR_MAP   = '0,
    parameter bit                                         DONT_CARE_ZERO = 1'b0
) (
    input  logic                             clk_i,
    input  logic                             sync_rst_i,

    input  logic [PIPE_CNT-1:0]              vreg_wr_valid_i,
    input  logic [PIPE_CNT-1:0]              vreg_wr_last_i,
    output logic [PIPE_CNT-1:0]              vreg_wr_ready_o,
    input  logic [PIPE_CNT*5-1:0]            vreg_wr_addr_i,
    input  logic [PIPE_CNT*VREG_W/8-1:0]     vreg_wr_be_i,
    input  logic [PIPE_CNT*VREG_W-1:0]       vreg_wr_data_i,

    output logic [VPORT_WR_CNT-1:0]          vregfile_wr_en_o,
    output logic [VPORT_WR_CNT*5-1:0]        vregfile_wr_addr_o,
    output logic [VPORT_WR_CNT*VREG_W/8-1:0] vregfile_wr_be_o,
    output logic [VPORT_WR_CNT*VREG_W-1:0]   vregfile_wr_data_o,
    output logic [31:0]                      vreg_wr_pend_o,

    output logic [VPORT_WR_CNT-1:0]          dbg_locked_o
);

    localparam int unsigned PIDX_W = (PIPE_CNT > 1) ? $clog2(PIPE_CNT) : 1;
    localparam int unsigned BE_W   = VREG_W / 8;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_e;

    // Returns {found, index} of the first set bit of m at or after start, wrapping to 0.
    function automatic logic [PIDX_W:0] rr_pick(input logic [PIPE_CNT-1:0] m,
                                                input logic [PIDX_W-1:0]   start);
        logic found;
        rr_pick = '0;
        found   = 1'b0;
        for (int j = 0; j < PIPE_CNT; j++) begin
            if (!found && m[j] && (PIDX_W'(j) >= start)) begin
                rr_pick = {1'b1, PIDX_W'(j)};
                found   = 1'b1;
            end
        end
        for (int j = 0; j < PIPE_CNT; j++) begin
            if (!found && m[j]) begin
                rr_pick = {1'b1, PIDX_W'(j)};
                found   = 1'b1;
            end
        end
    endfunction

    function automatic bit map_ok(input logic [VPORT_WR_CNT-1:0][PIPE_CNT-1:0] m);
        logic [PIPE_CNT-1:0] seen;
        logic [PIPE_CNT-1:0] dup;
        seen = '0;
        dup  = '0;
        for (int i = 0; i < VPORT_WR_CNT; i++) begin
            dup  = dup | (seen & m[i]);
            seen = seen | m[i];
        end
        map_ok = (dup == '0);
    endfunction

    if (!map_ok(VPORT_WR_MAP)) begin : g_map_check
        $error("vproc_vreg_wr_arbiter: a pipe is mapped to more than one write port");
    end

    logic [VPORT_WR_CNT-1:0][PIPE_CNT-1:0] port_gnt;

    for (genvar i = 0; i < VPORT_WR_CNT; i++) begin : g_port
        localparam logic [PIPE_CNT-1:0] PORT_MAP = VPORT_WR_MAP[i];
        localparam logic [PIDX_W:0]     RR_INIT  = rr_pick(PORT_MAP, '0);

        lock_state_e         state_q, state_d;
        logic [PIDX_W-1:0]   rr_q, rr_d;
        logic [PIDX_W-1:0]   lock_pipe_q, lock_pipe_d;
        logic [PIPE_CNT-1:0] cand;
        logic [PIPE_CNT-1:0] gnt;
        logic [PIDX_W:0]     pick;
        logic [PIDX_W:0]     nxt;
        logic                hs;
        logic                hs_last;

        logic [4:0]          addr_sel;
        logic [BE_W-1:0]     be_sel;
        logic [VREG_W-1:0]   data_sel;

        logic                en_q;
        logic [4:0]          addr_q;
        logic [BE_W-1:0]     be_q;
        logic [VREG_W-1:0]   data_q;

        assign cand = PORT_MAP & vreg_wr_valid_i;

        // A locked port only ever looks at its burst owner; reset masks every grant.
        always_comb begin
            pick = '0;
            gnt  = '0;
            if (state_q == ST_LOCKED) begin
                if (cand[lock_pipe_q]) begin
                    pick = {1'b1, lock_pipe_q};
                end
            end else begin
                pick = rr_pick(cand, rr_q);
            end
            if (pick[PIDX_W] && !sync_rst_i) begin
                gnt[pick[PIDX_W-1:0]] = 1'b1;
            end
        end

        assign hs      = |gnt;
        assign hs_last = |(gnt & vreg_wr_last_i);
        assign nxt     = rr_pick(PORT_MAP, pick[PIDX_W-1:0] + PIDX_W'(1));

        always_comb begin
            state_d     = state_q;
            rr_d        = rr_q;
            lock_pipe_d = lock_pipe_q;
            if (hs) begin
                if (hs_last) begin
                    state_d = ST_UNLOCKED;
                    rr_d    = nxt[PIDX_W-1:0];
                end else begin
                    state_d     = ST_LOCKED;
                    lock_pipe_d = pick[PIDX_W-1:0];
                end
            end
        end

        always_comb begin
            addr_sel = '0;
            be_sel   = '0;
            data_sel = '0;
            for (int j = 0; j < PIPE_CNT; j++) begin
                if (gnt[j]) begin
                    addr_sel = vreg_wr_addr_i[j*5 +: 5];
                    be_sel   = vreg_wr_be_i[j*BE_W +: BE_W];
                    data_sel = vreg_wr_data_i[j*VREG_W +: VREG_W];
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (sync_rst_i) begin
                state_q     <= ST_UNLOCKED;
                rr_q        <= RR_INIT[PIDX_W-1:0];
                lock_pipe_q <= '0;
                en_q        <= 1'b0;
                addr_q      <= '0;
                be_q        <= '0;
                data_q      <= '0;
            end else begin
                state_q     <= state_d;
                rr_q        <= rr_d;
                lock_pipe_q <= lock_pipe_d;
                en_q        <= hs;
                if (hs) begin
                    addr_q <= addr_sel;
                    be_q   <= be_sel;
                    data_q <= data_sel;
                end else if (DONT_CARE_ZERO) begin
                    addr_q <= '0;
                    be_q   <= '0;
                    data_q <= '0;
                end
            end
        end

        assign port_gnt[i]                             = gnt;
        assign vregfile_wr_en_o[i]                     = en_q;
        assign vregfile_wr_addr_o[i*5 +: 5]            = addr_q;
        assign vregfile_wr_be_o[i*BE_W +: BE_W]        = be_q;
        assign vregfile_wr_data_o[i*VREG_W +: VREG_W]  = data_q;
        assign dbg_locked_o[i]                         = (state_q == ST_LOCKED);
    end

    always_comb begin
        vreg_wr_ready_o = '0;
        for (int i = 0; i < VPORT_WR_CNT; i++) begin
            vreg_wr_ready_o = vreg_wr_ready_o | port_gnt[i];
        end
    end

    // Two ports writing the same register simply set the same bit.
    always_comb begin
        vreg_wr_pend_o = '0;
        for (int i = 0; i < VPORT_WR_CNT; i++) begin
            if (vregfile_wr_en_o[i]) begin
                vreg_wr_pend_o[vregfile_wr_addr_o[i*5 +: 5]] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vproc_vreg_wr_arbiter.sv
// Directed bench for vproc_vreg_wr_arbiter: two ports, port0 shared by pipes 0/1, port1 owned by pipe 2, pipe 3 unmapped.
// A behavioural model is checked every cycle; literal checks pin the scenarios.
module tb_vproc_vreg_wr_arbiter;

  localparam int VREG_W = 32;
  localparam int PORTS  = 2;
  localparam int PIPES  = 4;
  localparam int BE_W   = VREG_W / 8;
  localparam logic [PORTS-1:0][PIPES-1:0] MAP = {4'b0100, 4'b0011};

  // clock / reset
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [PIPES-1:0]         valid;
  logic [PIPES-1:0]         last;
  logic [PIPES-1:0]         ready;
  logic [4:0]               p_addr [PIPES];
  logic [BE_W-1:0]          p_be   [PIPES];
  logic [VREG_W-1:0]        p_data [PIPES];
  logic [PIPES*5-1:0]       addr_flat;
  logic [PIPES*BE_W-1:0]    be_flat;
  logic [PIPES*VREG_W-1:0]  data_flat;
  logic [PORTS-1:0]         wr_en;
  logic [PORTS*5-1:0]       wr_addr;
  logic [PORTS*BE_W-1:0]    wr_be;
  logic [PORTS*VREG_W-1:0]  wr_data;
  logic [31:0]              pend;
  logic [PORTS-1:0]         dbg_locked;

  for (genvar j = 0; j < PIPES; j++) begin : g_pack
    assign addr_flat[j*5 +: 5]         = p_addr[j];
    assign be_flat[j*BE_W +: BE_W]     = p_be[j];
    assign data_flat[j*VREG_W +: VREG_W] = p_data[j];
  end

  vproc_vreg_wr_arbiter #(
    .VREG_W         (VREG_W),
    .VPORT_WR_CNT   (PORTS),
    .PIPE_CNT       (PIPES),
    .VPORT_WR_MAP   (MAP),
    .DONT_CARE_ZERO (1'b1)
  ) dut (
    .clk_i              (clk),
    .sync_rst_i         (rst),
    .vreg_wr_valid_i    (valid),
    .vreg_wr_last_i     (last),
    .vreg_wr_ready_o    (ready),
    .vreg_wr_addr_i     (addr_flat),
    .vreg_wr_be_i       (be_flat),
    .vreg_wr_data_i     (data_flat),
    .vregfile_wr_en_o   (wr_en),
    .vregfile_wr_addr_o (wr_addr),
    .vregfile_wr_be_o   (wr_be),
    .vregfile_wr_data_o (wr_data),
    .vreg_wr_pend_o     (pend),
    .dbg_locked_o       (dbg_locked)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: pipe->port table, per-port pointer/lock, expected output registers
  int          port_of [PIPES] = '{0, 0, 1, -1};
  int          rr_init [PORTS] = '{0, 2};
  int          m_rr    [PORTS];
  bit          m_lock  [PORTS];
  int          m_lpipe [PORTS];
  bit          m_en    [PORTS];
  logic [4:0]  m_addr  [PORTS];
  logic [BE_W-1:0]   m_be   [PORTS];
  logic [VREG_W-1:0] m_data [PORTS];
  bit          model_on = 1'b0;
  int          g_m [PORTS];
  logic [PIPES-1:0] er;
  logic [31:0] ep;

  task automatic model_reset();
    for (int p = 0; p < PORTS; p++) begin
      m_rr[p] = rr_init[p]; m_lock[p] = 1'b0; m_lpipe[p] = 0;
      m_en[p] = 1'b0; m_addr[p] = '0; m_be[p] = '0; m_data[p] = '0;
    end
  endtask

  function automatic int next_on_port(input int p, input int g);
    for (int k = 1; k <= PIPES; k++) begin
      if (port_of[(g + k) % PIPES] == p) return (g + k) % PIPES;
    end
    return g;
  endfunction

  // compare process: inputs are stable from posedge+1 until the next posedge
  always @(negedge clk) begin
    if (model_on) begin
      er = '0;
      for (int p = 0; p < PORTS; p++) begin
        g_m[p] = -1;
        if (!rst) begin
          if (m_lock[p]) begin
            if (valid[m_lpipe[p]]) g_m[p] = m_lpipe[p];
          end else begin
            for (int k = 0; k < PIPES; k++) begin
              if (g_m[p] < 0 && port_of[(m_rr[p] + k) % PIPES] == p && valid[(m_rr[p] + k) % PIPES])
                g_m[p] = (m_rr[p] + k) % PIPES;
            end
          end
          if (g_m[p] >= 0) er[g_m[p]] = 1'b1;
        end
      end
      ep = '0;
      for (int p = 0; p < PORTS; p++) if (m_en[p]) ep = ep | (32'd1 << m_addr[p]);
      chk("model_ready", ready, er);
      chk("model_pend", pend, ep);
      for (int p = 0; p < PORTS; p++) begin
        chk("model_en", wr_en[p], m_en[p]);
        chk("model_addr", wr_addr[p*5 +: 5], m_addr[p]);
        chk("model_be", wr_be[p*BE_W +: BE_W], m_be[p]);
        chk("model_data", wr_data[p*VREG_W +: VREG_W], m_data[p]);
      end
      for (int p = 0; p < PORTS; p++) begin
        if (rst) begin
          m_rr[p] = rr_init[p]; m_lock[p] = 1'b0; m_lpipe[p] = 0;
          m_en[p] = 1'b0; m_addr[p] = '0; m_be[p] = '0; m_data[p] = '0;
        end else if (g_m[p] >= 0) begin
          m_en[p]   = 1'b1;
          m_addr[p] = p_addr[g_m[p]];
          m_be[p]   = p_be[g_m[p]];
          m_data[p] = p_data[g_m[p]];
          if (last[g_m[p]]) begin
            m_lock[p] = 1'b0;
            m_rr[p]   = next_on_port(p, g_m[p]);
          end else begin
            m_lock[p]  = 1'b1;
            m_lpipe[p] = g_m[p];
          end
        end else begin
          m_en[p] = 1'b0; m_addr[p] = '0; m_be[p] = '0; m_data[p] = '0;
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pipe(input int j, input bit v, input bit l, input logic [4:0] a);
    valid[j]  = v;
    last[j]   = l;
    p_addr[j] = a;
    p_be[j]   = a[3:0] ^ 4'h5;
    p_data[j] = {8'hD0 | 8'(j), 19'h0, a};
  endtask

  task automatic clear_all();
    for (int j = 0; j < PIPES; j++) set_pipe(j, 1'b0, 1'b1, 5'd0);
  endtask

  task automatic rst_pulse();
    tick();
    rst = 1'b1;
    clear_all();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    valid = '0;
    last = '0;
    clear_all();
    model_reset();

    // reset state, with a request present to show ready is masked
    tick();
    model_on = 1'b1;
    set_pipe(0, 1'b1, 1'b1, 5'd3);
    @(negedge clk);
    chk("rst_ready", ready, 4'b0000);
    chk("rst_en", wr_en, 2'b00);
    chk("rst_pend", pend, 32'h0);
    chk("rst_addr", wr_addr, 10'h0);
    tick();
    rst = 1'b0;

    // round-robin alternation on port0
    set_pipe(0, 1'b1, 1'b1, 5'd3);
    set_pipe(1, 1'b1, 1'b1, 5'd7);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr_ready", ready, (k % 2 == 0) ? 4'b0001 : 4'b0010);
      if (k > 0) chk("rr_addr", wr_addr[4:0], (k % 2 == 1) ? 5'd3 : 5'd7);
      tick();
    end
    clear_all();
    @(negedge clk);
    chk("rr_addr_last", wr_addr[4:0], 5'd7);
    chk("rr_en_last", wr_en[0], 1'b1);

    // burst lock: pipe0 four beats, pipe1 waits
    rst_pulse();
    set_pipe(1, 1'b1, 1'b1, 5'd9);
    for (int k = 0; k < 4; k++) begin
      set_pipe(0, 1'b1, (k == 3), 5'(4 + k));
      @(negedge clk);
      chk("burst_ready", ready, 4'b0001);
      if (k > 0) chk("burst_locked", dbg_locked[0], 1'b1);
      tick();
    end
    set_pipe(0, 1'b0, 1'b1, 5'd0);
    @(negedge clk);
    chk("burst_release", ready, 4'b0010);
    chk("burst_addr", wr_addr[4:0], 5'd7);

    // lock with a bubble: owner idles, pipe1 stays blocked
    rst_pulse();
    set_pipe(1, 1'b1, 1'b1, 5'd9);
    set_pipe(0, 1'b1, 1'b0, 5'd12);
    @(negedge clk);
    chk("bub_ready0", ready, 4'b0001);
    tick();
    set_pipe(0, 1'b0, 1'b0, 5'd12);
    @(negedge clk);
    chk("bub_ready1", ready, 4'b0000);
    chk("bub_en1", wr_en[0], 1'b1);
    tick();
    @(negedge clk);
    chk("bub_ready2", ready, 4'b0000);
    chk("bub_en2", wr_en[0], 1'b0);
    tick();
    set_pipe(0, 1'b1, 1'b1, 5'd13);
    @(negedge clk);
    chk("bub_ready3", ready, 4'b0001);
    chk("bub_en3", wr_en[0], 1'b0);
    tick();
    set_pipe(0, 1'b0, 1'b1, 5'd0);
    @(negedge clk);
    chk("bub_ready4", ready, 4'b0010);
    chk("bub_addr4", wr_addr[4:0], 5'd13);
    tick();
    clear_all();

    // two independent ports, unmapped pipe, duplicate address
    rst_pulse();
    set_pipe(0, 1'b1, 1'b1, 5'd1);
    set_pipe(2, 1'b1, 1'b1, 5'd2);
    set_pipe(3, 1'b1, 1'b1, 5'd9);
    @(negedge clk);
    chk("dual_ready", ready, 4'b0101);
    tick();
    set_pipe(0, 1'b1, 1'b1, 5'd5);
    set_pipe(2, 1'b1, 1'b1, 5'd5);
    @(negedge clk);
    chk("dual_en", wr_en, 2'b11);
    chk("dual_pend", pend, 32'h6);
    chk("dual_ready2", ready, 4'b0101);
    tick();
    clear_all();
    @(negedge clk);
    chk("dup_pend", pend, 32'h20);
    chk("dup_data1", wr_data[VREG_W +: VREG_W], 32'hD2000005);

    // reset in the middle of a pipe1 burst
    rst_pulse();
    set_pipe(0, 1'b1, 1'b1, 5'd10);
    @(negedge clk);
    chk("mid_ready0", ready, 4'b0001);
    tick();
    set_pipe(1, 1'b1, 1'b0, 5'd11);
    @(negedge clk);
    chk("mid_ready1", ready, 4'b0010);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_ready_rst", ready, 4'b0000);
    tick();
    rst = 1'b0;
    clear_all();
    @(negedge clk);
    chk("mid_en", wr_en, 2'b00);
    chk("mid_pend", pend, 32'h0);
    tick();
    set_pipe(0, 1'b1, 1'b1, 5'd14);
    set_pipe(1, 1'b1, 1'b1, 5'd15);
    @(negedge clk);
    chk("mid_first", ready, 4'b0001);
    tick();
    clear_all();

    // idle outputs are zeroed
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_addr", wr_addr, 10'h0);
      chk("idle_be", wr_be, 8'h0);
      chk("idle_data", wr_data, 64'h0);
      tick();
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
